// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sram_arb_pkg;

   // Arbiter mode: open arbitration, or m1 holding the port for a burst
   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   // Identifies which requester owns a grant or a read response
   typedef enum logic {
      MST_M0 = 1'b0,
      MST_M1 = 1'b1
   } mst_id_e;

   // Address bit that selects the MMIO status region instead of SRAM
   localparam int MMIO_ADDR_BIT = 31;

   function automatic logic is_mmio(input logic [31:0] addr);
      return addr[MMIO_ADDR_BIT];
   endfunction

endpackage

// File: rtl/sram_port_arb.sv
// Two-master (CPU m0, DMA m1) arbiter onto a single-port SRAM with an MMIO status window.
// Latency: grant is combinational in the request cycle; read data returns 1 cycle after grant.
// Backpressure: a master whose gnt is low holds its request; m1_lock stalls m0 for a whole burst.
// Build option: define SRAM_PORT_ARB_RR_EN for round-robin conflicts instead of
// fixed m0 priority with an m1 starvation counter.
module sram_port_arb
   import sram_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [3:0]  m0_ben,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [3:0]  m1_ben,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic        m1_lock,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        sram_cen,
   output logic        sram_wen,
   output logic [3:0]  sram_ben,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_din,
   input  logic [31:0] sram_dout,
   input  logic [31:0] mmio_rdata,
   output logic        mmio_sel
);

   arb_state_e  state_q, state_d;
   logic        gnt0, gnt1, gnt_any;
   logic        sel_we, sel_mmio;
   logic [3:0]  sel_ben;
   logic [31:0] sel_addr, sel_wdata;
   logic        rsp_vld_q, rsp_mmio_q;
   mst_id_e     rsp_owner_q;
   logic [31:0] rsp_mmio_dat_q;
   logic [31:0] rsp_rdata;

`ifdef SRAM_PORT_ARB_RR_EN
   mst_id_e     last_q, last_d;
`else
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   logic [3:0]  starve_cnt_q, starve_cnt_d;
`endif

   // Grant decision and next arbiter state; reset forces every grant low
   always_comb begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      state_d = state_q;
`ifdef SRAM_PORT_ARB_RR_EN
      last_d  = last_q;
`else
      starve_cnt_d = starve_cnt_q;
`endif
      if (!rst) begin
         case (state_q)
            ARB: begin
               if (m0_req && m1_req) begin
`ifdef SRAM_PORT_ARB_RR_EN
                  // Whoever won last time yields this conflict
                  if (last_q == MST_M0) gnt1 = 1'b1;
                  else                  gnt0 = 1'b1;
`else
                  // m0 wins unless m1 has already lost STARVE_MAX conflicts
                  if (starve_cnt_q == STARVE_LIM) begin
                     gnt1 = 1'b1;
                  end else begin
                     gnt0 = 1'b1;
                     if (starve_cnt_q != 4'hF) starve_cnt_d = starve_cnt_q + 4'd1;
                  end
`endif
               end else begin
                  gnt0 = m0_req;
                  gnt1 = m1_req;
               end
`ifndef SRAM_PORT_ARB_RR_EN
               if (gnt1) starve_cnt_d = '0;
`endif
               if (gnt1 && m1_lock) state_d = LOCK;
            end
            LOCK: begin
               // m0 is stalled and the starvation count is frozen during a burst
               gnt1 = m1_req;
               if (!m1_req || !m1_lock) state_d = ARB;
            end
         endcase
`ifdef SRAM_PORT_ARB_RR_EN
         if (gnt0)      last_d = MST_M0;
         else if (gnt1) last_d = MST_M1;
`endif
      end
   end

   // Arbiter state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB;
`ifdef SRAM_PORT_ARB_RR_EN
         last_q  <= MST_M1;
`else
         starve_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
`ifdef SRAM_PORT_ARB_RR_EN
         last_q  <= last_d;
`else
         starve_cnt_q <= starve_cnt_d;
`endif
      end
   end

   assign gnt_any   = gnt0 | gnt1;
   assign sel_we    = gnt1 ? m1_we    : m0_we;
   assign sel_ben   = gnt1 ? m1_ben   : m0_ben;
   assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
   assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;
   assign sel_mmio  = gnt_any & is_mmio(sel_addr);

   assign m0_gnt    = gnt0;
   assign m1_gnt    = gnt1;
   assign sram_cen  = gnt_any;
   // MMIO is read-only from this port: writes there never reach the SRAM
   assign sram_wen  = gnt_any & sel_we & ~sel_mmio;
   assign sram_ben  = gnt_any ? sel_ben   : '0;
   assign sram_addr = gnt_any ? sel_addr  : '0;
   assign sram_din  = gnt_any ? sel_wdata : '0;
   assign mmio_sel  = sel_mmio;

   // Read response tracking: owner, source and MMIO word captured at grant
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_vld_q      <= 1'b0;
         rsp_mmio_q     <= 1'b0;
         rsp_owner_q    <= MST_M0;
         rsp_mmio_dat_q <= '0;
      end else begin
         rsp_vld_q      <= gnt_any & ~sel_we;
         rsp_mmio_q     <= sel_mmio;
         rsp_owner_q    <= gnt1 ? MST_M1 : MST_M0;
         rsp_mmio_dat_q <= sel_mmio ? mmio_rdata : '0;
      end
   end

   // A response pending when reset arrives is dropped, not presented
   assign rsp_rdata = rsp_mmio_q ? rsp_mmio_dat_q : sram_dout;
   assign m0_rvalid = ~rst & rsp_vld_q & (rsp_owner_q == MST_M0);
   assign m1_rvalid = ~rst & rsp_vld_q & (rsp_owner_q == MST_M1);
   assign m0_rdata  = m0_rvalid ? rsp_rdata : '0;
   assign m1_rdata  = m1_rvalid ? rsp_rdata : '0;

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb: reset, single access, conflicts, lock bursts, MMIO.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected grant sequences follow the build: fixed priority + starvation, or round-robin.
module tb_sram_port_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we;
   logic [3:0]  m0_ben;
   logic [31:0] m0_addr, m0_wdata;
   logic        m0_gnt, m0_rvalid;
   logic [31:0] m0_rdata;
   logic        m1_req, m1_we, m1_lock;
   logic [3:0]  m1_ben;
   logic [31:0] m1_addr, m1_wdata;
   logic        m1_gnt, m1_rvalid;
   logic [31:0] m1_rdata;
   logic        sram_cen, sram_wen;
   logic [3:0]  sram_ben;
   logic [31:0] sram_addr, sram_din, sram_dout;
   logic [31:0] mmio_rdata;
   logic        mmio_sel;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] SRAM_WORD = 32'hDEAD_BEEF;

   always #5 clk = ~clk;

   sram_port_arb #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_ben(m0_ben), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_ben(m1_ben), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .m1_rdata(m1_rdata),
      .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_ben(sram_ben), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout),
      .mmio_rdata(mmio_rdata), .mmio_sel(mmio_sel)
   );

   // Expected winner of the i-th consecutive conflict cycle, starting from a fresh arbiter
   function automatic bit exp_m1(input int i);
`ifdef SRAM_PORT_ARB_RR_EN
      return (i % 2) == 1;
`else
      return (i % 5) == 4;
`endif
   endfunction

   task automatic idle();
      m0_req = 0; m0_we = 0; m0_ben = 4'h0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_ben = 4'h0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic both_read();
      m0_req = 1; m0_we = 0; m0_ben = 4'hF; m0_addr = 32'h0000_0010;
      m1_req = 1; m1_we = 0; m1_ben = 4'hF; m1_addr = 32'h0000_0020; m1_lock = 0;
   endtask

   task automatic test_reset();
      bit e1;
      rst = 1; both_read();
      step(); step();
      @(negedge clk);
      total++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt: got m0=%b m1=%b want 0 0", m0_gnt, m1_gnt); end
      total++; if (sram_cen !== 1'b0 || sram_addr !== 32'h0) begin bad++; $display("FAIL rst_sram: got cen=%b addr=%h want 0 0", sram_cen, sram_addr); end
      total++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
         bad++; $display("FAIL rst_rsp: got rv0=%b rv1=%b rd0=%h rd1=%h want all 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata); end
      // build up some conflict history, then reset mid-stream
      step(); rst = 0;
      step(); step(); step();
      rst = 1;
      @(negedge clk);
      total++; if (m0_gnt !== 1'b0 || m0_rvalid !== 1'b0) begin bad++; $display("FAIL rst_mid: got gnt=%b rvalid=%b want 0 0", m0_gnt, m0_rvalid); end
      step(); rst = 0;
      for (int i = 0; i < 5; i++) begin
         e1 = exp_m1(i);
         @(negedge clk);
         total++; if (m1_gnt !== e1 || m0_gnt !== !e1) begin
            bad++; $display("FAIL rst_restart[%0d]: got m0=%b m1=%b want m0=%b m1=%b", i, m0_gnt, m1_gnt, !e1, e1); end
         step();
      end
      idle();
   endtask

   task automatic test_single_read();
      step();
      m0_req = 1; m0_we = 0; m0_ben = 4'hF; m0_addr = 32'h0000_0100;
      @(negedge clk);
      total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin bad++; $display("FAIL rd_gnt: got m0=%b m1=%b want 1 0", m0_gnt, m1_gnt); end
      total++; if (sram_cen !== 1'b1 || sram_wen !== 1'b0 || sram_addr !== 32'h100 || mmio_sel !== 1'b0) begin
         bad++; $display("FAIL rd_port: got cen=%b wen=%b addr=%h sel=%b want 1 0 100 0", sram_cen, sram_wen, sram_addr, mmio_sel); end
      step(); idle();
      @(negedge clk);
      total++; if (m0_rvalid !== 1'b1 || m0_rdata !== SRAM_WORD) begin
         bad++; $display("FAIL rd_rsp: got rvalid=%b rdata=%h want 1 %h", m0_rvalid, m0_rdata, SRAM_WORD); end
      total++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL rd_other: got rvalid=%b rdata=%h want 0 0", m1_rvalid, m1_rdata); end
      total++; if (sram_cen !== 1'b0 || sram_addr !== 32'h0) begin bad++; $display("FAIL rd_idle: got cen=%b addr=%h want 0 0", sram_cen, sram_addr); end
   endtask

   task automatic test_single_write();
      step();
      m1_req = 1; m1_we = 1; m1_ben = 4'h3; m1_addr = 32'h0000_0040; m1_wdata = 32'h1234_5678;
      @(negedge clk);
      total++; if (m1_gnt !== 1'b1 || sram_wen !== 1'b1 || sram_ben !== 4'h3 || sram_din !== 32'h1234_5678 || sram_addr !== 32'h40) begin
         bad++; $display("FAIL wr_port: got gnt=%b wen=%b ben=%h din=%h addr=%h want 1 1 3 12345678 40", m1_gnt, sram_wen, sram_ben, sram_din, sram_addr); end
      step(); idle();
      @(negedge clk);
      total++; if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0) begin bad++; $display("FAIL wr_norv: got rv0=%b rv1=%b want 0 0", m0_rvalid, m1_rvalid); end
   endtask

   task automatic test_conflict();
      bit e1, p1;
      step();
      both_read();
      p1 = 0;
      for (int i = 0; i < 10; i++) begin
         e1 = exp_m1(i);
         @(negedge clk);
         total++; if (m1_gnt !== e1 || m0_gnt !== !e1) begin
            bad++; $display("FAIL conflict[%0d]: got m0=%b m1=%b want m0=%b m1=%b", i, m0_gnt, m1_gnt, !e1, e1); end
         if (i > 0) begin
            total++; if (m1_rvalid !== p1 || m0_rvalid !== !p1 || m1_rdata !== (p1 ? SRAM_WORD : 32'h0)) begin
               bad++; $display("FAIL conflict_rsp[%0d]: got rv0=%b rv1=%b rd1=%h want rv0=%b rv1=%b", i, m0_rvalid, m1_rvalid, m1_rdata, !p1, p1); end
         end
         p1 = e1;
         step();
      end
      idle();
   endtask

   task automatic test_lock_burst();
      step();
      m1_req = 1; m1_we = 1; m1_ben = 4'hF; m1_lock = 1; m1_addr = 32'h0000_0400;
      for (int i = 0; i < 8; i++) begin
         m1_addr  = 32'h0000_0400 + 32'(i * 4);
         m1_wdata = 32'hB000_0000 + 32'(i);
         if (i >= 1) begin m0_req = 1; m0_we = 0; m0_ben = 4'hF; m0_addr = 32'h0000_0008; end
         if (i == 7) m1_lock = 0;
         @(negedge clk);
         total++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || sram_din !== 32'hB000_0000 + 32'(i)) begin
            bad++; $display("FAIL lock_beat[%0d]: got m0=%b m1=%b din=%h want 0 1 %h", i, m0_gnt, m1_gnt, sram_din, 32'hB000_0000 + 32'(i)); end
         step();
      end
      m1_req = 0; m1_we = 0;
      @(negedge clk);
      total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || m1_rvalid !== 1'b0) begin
         bad++; $display("FAIL lock_after: got m0=%b m1=%b rv1=%b want 1 0 0", m0_gnt, m1_gnt, m1_rvalid); end
      step(); idle();
   endtask

   task automatic test_lock_release();
      step();
      m1_req = 1; m1_we = 1; m1_lock = 1; m1_ben = 4'hF; m1_addr = 32'h0000_0500;
      @(negedge clk);
      total++; if (m1_gnt !== 1'b1) begin bad++; $display("FAIL rel_enter: got m1=%b want 1", m1_gnt); end
      step();
      m1_req = 0; m0_req = 1; m0_we = 0; m0_ben = 4'hF; m0_addr = 32'h0000_000C;
      @(negedge clk);
      total++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || sram_cen !== 1'b0) begin
         bad++; $display("FAIL rel_gap: got m0=%b m1=%b cen=%b want 0 0 0", m0_gnt, m1_gnt, sram_cen); end
      step();
      @(negedge clk);
      total++; if (m0_gnt !== 1'b1) begin bad++; $display("FAIL rel_m0: got m0=%b want 1", m0_gnt); end
      step(); idle();
   endtask

   task automatic test_mmio();
      step();
      m0_req = 1; m0_we = 1; m0_ben = 4'hF; m0_addr = 32'h8000_0000; m0_wdata = 32'h0BAD_F00D;
      @(negedge clk);
      total++; if (m0_gnt !== 1'b1 || sram_wen !== 1'b0 || mmio_sel !== 1'b1 || sram_cen !== 1'b1) begin
         bad++; $display("FAIL mmio_wr: got gnt=%b wen=%b sel=%b cen=%b want 1 0 1 1", m0_gnt, sram_wen, mmio_sel, sram_cen); end
      step();
      m0_we = 0; m0_addr = 32'hC000_0000; mmio_rdata = 32'hA5A5_0001;
      @(negedge clk);
      total++; if (mmio_sel !== 1'b1 || sram_wen !== 1'b0 || m0_rvalid !== 1'b0) begin
         bad++; $display("FAIL mmio_rd_gnt: got sel=%b wen=%b rv=%b want 1 0 0", mmio_sel, sram_wen, m0_rvalid); end
      step(); idle();
      mmio_rdata = 32'hFFFF_0000;
      @(negedge clk);
      total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA5A5_0001) begin
         bad++; $display("FAIL mmio_rsp: got rv=%b rdata=%h want 1 a5a50001", m0_rvalid, m0_rdata); end
      total++; if (mmio_sel !== 1'b0) begin bad++; $display("FAIL mmio_idle: got sel=%b want 0", mmio_sel); end
   endtask

   task automatic test_reset_mid_lock();
      bit e1;
      step();
      m1_req = 1; m1_we = 0; m1_ben = 4'hF; m1_addr = 32'h0000_0200; m1_lock = 1;
      @(negedge clk);
      total++; if (m1_gnt !== 1'b1) begin bad++; $display("FAIL rml_enter: got m1=%b want 1", m1_gnt); end
      step();
      @(negedge clk);
      total++; if (m1_gnt !== 1'b1 || m1_rvalid !== 1'b1 || m1_rdata !== SRAM_WORD) begin
         bad++; $display("FAIL rml_beat: got gnt=%b rv=%b rd=%h want 1 1 %h", m1_gnt, m1_rvalid, m1_rdata, SRAM_WORD); end
      step();
      rst = 1; m0_req = 1; m0_we = 0; m0_ben = 4'hF; m0_addr = 32'h0000_0010;
      @(negedge clk);
      total++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || sram_cen !== 1'b0 || m1_rvalid !== 1'b0) begin
         bad++; $display("FAIL rml_rst: got m0=%b m1=%b cen=%b rv1=%b want 0 0 0 0", m0_gnt, m1_gnt, sram_cen, m1_rvalid); end
      step();
      rst = 0; both_read();
      for (int i = 0; i < 5; i++) begin
         e1 = exp_m1(i);
         @(negedge clk);
         total++; if (m1_gnt !== e1 || m0_gnt !== !e1) begin
            bad++; $display("FAIL rml_after[%0d]: got m0=%b m1=%b want m0=%b m1=%b", i, m0_gnt, m1_gnt, !e1, e1); end
         if (i == 0) begin
            total++; if (m1_rvalid !== 1'b0) begin bad++; $display("FAIL rml_drop: got rv1=%b want 0", m1_rvalid); end
         end
         step();
      end
      idle();
   endtask

   initial begin
      rst = 1;
      idle();
      sram_dout  = SRAM_WORD;
      mmio_rdata = 32'h0000_5A5A;
      test_reset();
      test_single_read();
      test_single_write();
      test_conflict();
      test_lock_burst();
      test_lock_release();
      test_mmio();
      test_reset_mid_lock();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
